bcd_serial_subtractor: RTL

//  Digit-serial, multi-digit BCD subtractor: computes |A - B| and a sign flag for

---
 rtl/bcd_serial_subtractor_pkg.sv | 17 +
 rtl/bcd_digit_sub.sv | 25 ++
 rtl/bcd_serial_subtractor.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared constants for the digit-serial BCD subtractor: digit geometry,
// FSM state encoding and a digit validity helper.
package bcd_serial_subtractor_pkg;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam int unsigned BCD_MAX_DIGIT = 9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_NEG  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic digit_ok(input logic [BCD_DIGIT_W-1:0] d);
    return d <= BCD_DIGIT_W'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of x - y - bin with decimal borrow; x, y must be 0..9.
module bcd_digit_sub
  import bcd_serial_subtractor_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] x,
  input  logic [BCD_DIGIT_W-1:0] y,
  input  logic                   bin,
  output logic [BCD_DIGIT_W-1:0] d,
  output logic                   bout
);

  logic signed [4:0] t;

  always_comb begin
    t = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({4'b0000, bin});
    if (t < 5'sd0) begin
      d    = BCD_DIGIT_W'(t + 5'sd10);
      bout = 1'b1;
    end else begin
      d    = BCD_DIGIT_W'(t);
      bout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial |a - b| on packed BCD, LSD first, with sign and invalid-digit flags.
// A negative raw result is turned into its magnitude by a second serial pass.
module bcd_serial_subtractor
  import bcd_serial_subtractor_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] diff,
  output logic                          neg,
  output logic                          invalid
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef logic [DIGITS-1:0][BCD_DIGIT_W-1:0] bcd_vec_t;

  logic [1:0]       state_q, state_nxt;
  logic [IW-1:0]    idx_q, idx_nxt;
  logic             borrow_q, borrow_nxt;
  bcd_vec_t         a_q, a_nxt, b_q, b_nxt, diff_q, diff_nxt;
  logic             neg_q, neg_nxt, invalid_q, invalid_nxt;
  logic             busy_q, busy_nxt, done_q, done_nxt;

  bcd_vec_t         a_in, b_in;
  logic             any_bad;
  logic             last;
  logic [BCD_DIGIT_W-1:0] x_sel, y_sel, d_out;
  logic             bout;

  assign a_in = a;
  assign b_in = b;
  assign last = (idx_q == IW'(DIGITS - 1));

  // NEG pass computes 0 - diff_i - borrow to convert tens complement to magnitude
  assign x_sel = (state_q == ST_NEG) ? '0 : a_q[idx_q];
  assign y_sel = (state_q == ST_NEG) ? diff_q[idx_q] : b_q[idx_q];

  bcd_digit_sub u_digit (
    .x    (x_sel),
    .y    (y_sel),
    .bin  (borrow_q),
    .d    (d_out),
    .bout (bout)
  );

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!digit_ok(a_in[i]) || !digit_ok(b_in[i])) any_bad = 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    idx_nxt     = idx_q;
    borrow_nxt  = borrow_q;
    a_nxt       = a_q;
    b_nxt       = b_q;
    diff_nxt    = diff_q;
    neg_nxt     = neg_q;
    invalid_nxt = invalid_q;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_nxt       = a_in;
          b_nxt       = b_in;
          diff_nxt    = '0;
          neg_nxt     = 1'b0;
          invalid_nxt = 1'b0;
          borrow_nxt  = 1'b0;
          idx_nxt     = '0;
          if (any_bad) begin
            invalid_nxt = 1'b1;
            state_nxt   = ST_DONE;
            done_nxt    = 1'b1;
          end else begin
            state_nxt = ST_SUB;
            busy_nxt  = 1'b1;
          end
        end
      end
      ST_SUB, ST_NEG: begin
        busy_nxt        = 1'b1;
        diff_nxt[idx_q] = d_out;
        borrow_nxt      = bout;
        idx_nxt         = idx_q + IW'(1);
        if (last) begin
          idx_nxt    = '0;
          borrow_nxt = 1'b0;
          // Final borrow of the NEG pass is meaningless and dropped
          if (state_q == ST_SUB && bout) begin
            state_nxt = ST_NEG;
            neg_nxt   = 1'b1;
          end else begin
            state_nxt = ST_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      borrow_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      diff_q    <= '0;
      neg_q     <= 1'b0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      idx_q     <= idx_nxt;
      borrow_q  <= borrow_nxt;
      a_q       <= a_nxt;
      b_q       <= b_nxt;
      diff_q    <= diff_nxt;
      neg_q     <= neg_nxt;
      invalid_q <= invalid_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign diff    = diff_q;
  assign neg     = neg_q;
  assign invalid = invalid_q;

endmodule
